// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to 5-digit BCD converter (double dabble, one bit per clock).
// Define BIN2BCD_SIGNED_EN to treat bin as two's complement and report the sign on neg.
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  neg
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_reg,   state_next;
  logic [WIDTH-1:0]     operand_reg, operand_next;
  logic                 sign_reg,    sign_next;
  logic [DIGITS*4-1:0]  scratch_reg, scratch_next;
  logic [CW-1:0]        count_reg,   count_next;
  logic [DIGITS*4-1:0]  bcd_reg,     bcd_next;
  logic                 neg_reg,     neg_next;
  logic                 done_reg,    done_next;

  logic [WIDTH-1:0]     mag;
  logic                 sign_in;
  logic [DIGITS*4-1:0]  adj;

`ifdef BIN2BCD_SIGNED_EN
  // 16'h8000 negates to itself, which read unsigned is exactly 32768
  assign mag     = bin[WIDTH-1] ? (~bin + WIDTH'(1)) : bin;
  assign sign_in = bin[WIDTH-1];
`else
  assign mag     = bin;
  assign sign_in = 1'b0;
`endif

  // Add-3 correction on every digit before it is doubled by the shift
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5) ?
                              (scratch_reg[gi*4 +: 4] + 4'd3) :
                              scratch_reg[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      operand_reg <= '0;
      sign_reg    <= 1'b0;
      scratch_reg <= '0;
      count_reg   <= '0;
      bcd_reg     <= '0;
      neg_reg     <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      operand_reg <= operand_next;
      sign_reg    <= sign_next;
      scratch_reg <= scratch_next;
      count_reg   <= count_next;
      bcd_reg     <= bcd_next;
      neg_reg     <= neg_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    operand_next = operand_reg;
    sign_next    = sign_reg;
    scratch_next = scratch_reg;
    count_next   = count_reg;
    bcd_next     = bcd_reg;
    neg_next     = neg_reg;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          operand_next = mag;
          sign_next    = sign_in;
          scratch_next = '0;
          count_next   = '0;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_next, operand_next} = {adj, operand_reg} << 1;
        count_next = count_reg + CW'(1);
        if (count_reg == CW'(WIDTH - 1)) begin
          bcd_next   = scratch_next;
          neg_next   = sign_reg;
          done_next  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state_reg != IDLE);
  assign done = done_reg;
  assign bcd  = bcd_reg;
  assign neg  = neg_reg;

endmodule
